board_refresh: RTL and testbench



---
 rtl/ttt_pkg.sv | 30 +++
 rtl/board_refresh_if.sv | 24 ++
 rtl/refresh_dwell_timer.sv | 41 ++++
 rtl/board_refresh.sv | 185 ++++++++++++++++++
 tb/tb_board_refresh.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell codes, the 9-cell board vector, game and
// refresh state codes, and the row/column to cell mapping of the LED board.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_USER  = 2'b01,
    CELL_CPU   = 2'b10,
    CELL_BOTH  = 2'b11
  } cell_t;

  // Nine 2-bit cell codes; element i holds a cell_t value for cell i.
  typedef logic [8:0][1:0] board_t;

  localparam logic [2:0] s_start_game = 3'b000;
  localparam logic [2:0] s_play       = 3'b001;
  localparam logic [2:0] s_result     = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } refresh_state_t;

  // Physical column c of row r shows cell 3*(2-c)+r.
  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(3 * (2 - int'(col)) + int'(row));
  endfunction

endpackage

// File: rtl/board_refresh_if.sv
// Board-vector bus from the game-control modules to the LED display driver.
interface board_refresh_if;
  import ttt_pkg::*;

  logic       load;
  board_t     board;
  logic [8:0] win_mask;
  logic [2:0] row_sel;
  logic [2:0] col_red;
  logic [2:0] col_green;
  logic       frame_done;
  logic       lights_ready;

  modport master (
    output load, board, win_mask,
    input  row_sel, col_red, col_green, frame_done, lights_ready
  );

  modport slave (
    input  load, board, win_mask,
    output row_sel, col_red, col_green, frame_done, lights_ready
  );

endinterface

// File: rtl/refresh_dwell_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot; expire is high during
// the last cycle of the slot, expire_next is its value for the next cycle.
module refresh_dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] len,
  output logic         expire,
  output logic         expire_next
);

  logic [W-1:0] cnt_reg, cnt_next;
  logic         expire_reg;

  // The count holds the cycles still to go after the current one.
  always_comb begin
    cnt_next = cnt_reg;
    if (start) begin
      cnt_next = len - 1'b1;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign expire_next = (cnt_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      expire_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      expire_reg <= expire_next;
    end
  end

  assign expire = expire_reg;

endmodule

// File: rtl/board_refresh.sv
// 3x3 bicolor LED board scanner: double-buffered board latch, blanked row
// multiplexing, win-cell blinking and a "pattern fully shown" flag.
module board_refresh
  import ttt_pkg::*;
#(
  parameter int ROW_CYCLES   = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 2
) (
  input  logic            clk,
  input  logic            rst,
  board_refresh_if.slave  bus
);

  localparam int MAX_DWELL = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int DW        = $clog2(MAX_DWELL + 1);
  localparam int BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] ROW_LEN    = DW'(ROW_CYCLES);
  localparam logic [DW-1:0] BLANK_LEN  = DW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  refresh_state_t state_reg, state_next;
  logic [1:0]     row_reg, row_next;
  board_t         active_board_reg, active_board_next;
  board_t         pending_board_reg, pending_board_next;
  logic [8:0]     active_mask_reg, active_mask_next;
  logic [8:0]     pending_mask_reg, pending_mask_next;
  logic           pending_valid_reg, pending_valid_next;
  logic           blink_phase_reg, blink_phase_next;
  logic [BW-1:0]  blink_cnt_reg, blink_cnt_next;
  logic           lights_ready_reg, lights_ready_next;
  logic [2:0]     row_sel_reg, row_sel_next;
  logic [2:0]     col_red_reg, col_red_next;
  logic [2:0]     col_green_reg, col_green_next;
  logic           frame_done_reg, frame_done_next;

  logic           dwell_start, dwell_expire, dwell_expire_next;
  logic [DW-1:0]  dwell_len;
  logic           frame_end;

  refresh_dwell_timer #(.W(DW)) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .start       (dwell_start),
    .len         (dwell_len),
    .expire      (dwell_expire),
    .expire_next (dwell_expire_next)
  );

  always_comb begin
    state_next         = state_reg;
    row_next           = row_reg;
    active_board_next  = active_board_reg;
    active_mask_next   = active_mask_reg;
    pending_board_next = pending_board_reg;
    pending_mask_next  = pending_mask_reg;
    pending_valid_next = pending_valid_reg;
    blink_phase_next   = blink_phase_reg;
    blink_cnt_next     = blink_cnt_reg;
    lights_ready_next  = lights_ready_reg;
    dwell_start        = 1'b0;
    dwell_len          = BLANK_LEN;
    frame_end          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.load) begin
          active_board_next = bus.board;
          active_mask_next  = bus.win_mask;
          state_next        = ST_BLANK;
          row_next          = 2'd0;
          dwell_start       = 1'b1;
        end
      end
      ST_BLANK: begin
        if (dwell_expire) begin
          state_next  = ST_SHOW;
          dwell_start = 1'b1;
          dwell_len   = ROW_LEN;
        end
      end
      ST_SHOW: begin
        if (dwell_expire) begin
          state_next  = ST_BLANK;
          dwell_start = 1'b1;
          if (row_reg == 2'd2) begin
            row_next  = 2'd0;
            frame_end = 1'b1;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Buffered boards swap in only here, so a frame is never torn.
    if (frame_end) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next   = '0;
        blink_phase_next = !blink_phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
      if (pending_valid_reg) begin
        active_board_next  = pending_board_reg;
        active_mask_next   = pending_mask_reg;
        pending_valid_next = 1'b0;
      end else begin
        lights_ready_next = 1'b1;
      end
    end

    // A load coinciding with the frame boundary lands after the old pending swap.
    if (bus.load) begin
      lights_ready_next = 1'b0;
      if (state_reg != ST_IDLE) begin
        pending_board_next = bus.board;
        pending_mask_next  = bus.win_mask;
        pending_valid_next = 1'b1;
      end
    end

    row_sel_next    = (state_next == ST_SHOW) ? 3'(3'b001 << row_next) : 3'b000;
    frame_done_next = (state_next == ST_SHOW) && (row_next == 2'd2) && dwell_expire_next;
  end

  // Column bit gi drives cell 3*gi+row, i.e. physical column 2-gi.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_col
      logic [3:0] idx;
      cell_t      code;
      logic       dark;
      assign idx  = cell_index(row_next, 2'(2 - gi));
      assign code = cell_t'(active_board_next[idx]);
      assign dark = active_mask_next[idx] & blink_phase_next;
      assign col_red_next[gi]   = (state_next == ST_SHOW) && !dark &&
                                  (code == CELL_USER || code == CELL_BOTH);
      assign col_green_next[gi] = (state_next == ST_SHOW) && !dark &&
                                  (code == CELL_CPU || code == CELL_BOTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      row_reg           <= 2'd0;
      active_board_reg  <= '0;
      active_mask_reg   <= '0;
      pending_board_reg <= '0;
      pending_mask_reg  <= '0;
      pending_valid_reg <= 1'b0;
      blink_phase_reg   <= 1'b0;
      blink_cnt_reg     <= '0;
      lights_ready_reg  <= 1'b0;
      row_sel_reg       <= '0;
      col_red_reg       <= '0;
      col_green_reg     <= '0;
      frame_done_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      row_reg           <= row_next;
      active_board_reg  <= active_board_next;
      active_mask_reg   <= active_mask_next;
      pending_board_reg <= pending_board_next;
      pending_mask_reg  <= pending_mask_next;
      pending_valid_reg <= pending_valid_next;
      blink_phase_reg   <= blink_phase_next;
      blink_cnt_reg     <= blink_cnt_next;
      lights_ready_reg  <= lights_ready_next;
      row_sel_reg       <= row_sel_next;
      col_red_reg       <= col_red_next;
      col_green_reg     <= col_green_next;
      frame_done_reg    <= frame_done_next;
    end
  end

  assign bus.row_sel      = row_sel_reg;
  assign bus.col_red      = col_red_reg;
  assign bus.col_green    = col_green_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.lights_ready = lights_ready_reg;

endmodule

// File: tb/tb_board_refresh.sv
// Bench for board_refresh (ROW_CYCLES=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
// table of single-board frames plus multi-frame sequences, via a scoreboard queue.
module tb_board_refresh;
  import ttt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_refresh_if bus();

  board_refresh #(
    .ROW_CYCLES   (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] row_sel;
    logic [2:0] red;
    logic [2:0] green;
    logic       fd;
    logic       lr;
  } exp_t;

  // Cell sets are bit-per-cell; expected rows are packed {row2,row1,row0}.
  typedef struct {
    logic [8:0] red_cells;
    logic [8:0] green_cells;
    logic [8:0] mask;
    logic [8:0] exp_red;
    logic [8:0] exp_green;
  } vec_t;

  localparam logic [8:0]  MENU_CELLS = 9'h1F4;
  localparam logic [8:0]  MENU_ROWS  = 9'b111_110_100;
  localparam logic [14:0] LR_OFF     = 15'h0000;
  localparam logic [14:0] LR_ON      = 15'h7FFF;

  exp_t  sb_q[$];
  vec_t  vecs[8];
  int    errors = 0;
  int    checks = 0;
  string phase_name = "init";

  function automatic logic [17:0] mk_board(input logic [8:0] r, input logic [8:0] g);
    logic [17:0] b;
    for (int i = 0; i < 9; i++) begin
      b[2*i]   = r[i];
      b[2*i+1] = g[i];
    end
    return b;
  endfunction

  task automatic push_frame(input logic [8:0] red9, input logic [8:0] green9,
                            input logic [14:0] lr);
    exp_t e;
    int   k = 0;
    for (int r = 0; r < 3; r++) begin
      e.row_sel = 3'b000; e.red = 3'b000; e.green = 3'b000; e.fd = 1'b0; e.lr = lr[k];
      sb_q.push_back(e);
      k++;
      for (int j = 0; j < 4; j++) begin
        e.row_sel = 3'(1 << r);
        e.red     = red9[3*r +: 3];
        e.green   = green9[3*r +: 3];
        e.fd      = (r == 2 && j == 3);
        e.lr      = lr[k];
        sb_q.push_back(e);
        k++;
      end
    end
  endtask

  task automatic push_dark(input int n);
    exp_t e;
    e.row_sel = 3'b000; e.red = 3'b000; e.green = 3'b000; e.fd = 1'b0; e.lr = 1'b0;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at t=%0t", phase_name, $time);
      return;
    end
    e = sb_q.pop_front();
    if (bus.row_sel !== e.row_sel || bus.col_red !== e.red || bus.col_green !== e.green ||
        bus.frame_done !== e.fd || bus.lights_ready !== e.lr) begin
      errors++;
      $display("FAIL %s t=%0t: got row_sel=%b red=%b green=%b fd=%b lr=%b, need row_sel=%b red=%b green=%b fd=%b lr=%b",
               phase_name, $time, bus.row_sel, bus.col_red, bus.col_green, bus.frame_done,
               bus.lights_ready, e.row_sel, e.red, e.green, e.fd, e.lr);
    end
  endtask

  task automatic check_n(input int n);
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  task automatic drain();
    while (sb_q.size() != 0) check_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  // Called at a negedge: load is sampled by the following posedge.
  task automatic pulse_load(input logic [17:0] b, input logic [8:0] m);
    bus.board    = b;
    bus.win_mask = m;
    bus.load     = 1'b1;
    $display("load %s: board=%h mask=%h t=%0t", phase_name, b, m, $time);
    @(posedge clk);
    #1 bus.load = 1'b0;
  endtask

  task automatic load_idle(input logic [17:0] b, input logic [8:0] m);
    @(negedge clk);
    pulse_load(b, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.board    = '0;
    bus.win_mask = '0;

    vecs[0] = '{MENU_CELLS, MENU_CELLS, 9'h000, MENU_ROWS, MENU_ROWS};
    vecs[1] = '{9'h1FF, 9'h000, 9'h000, 9'b111_111_111, 9'b000_000_000};
    vecs[2] = '{9'h000, 9'h1FF, 9'h000, 9'b000_000_000, 9'b111_111_111};
    vecs[3] = '{9'h001, 9'h000, 9'h000, 9'b000_000_001, 9'b000_000_000};
    vecs[4] = '{9'h000, 9'h100, 9'h000, 9'b000_000_000, 9'b100_000_000};
    vecs[5] = '{9'h010, 9'h010, 9'h010, 9'b000_010_000, 9'b000_010_000};
    vecs[6] = '{9'h020, 9'h002, 9'h000, 9'b010_000_000, 9'b000_001_000};
    vecs[7] = '{9'h008, 9'h040, 9'h000, 9'b000_000_010, 9'b000_000_100};

    phase_name = "reset_idle";
    do_reset();
    push_dark(50);
    drain();

    for (int v = 0; v < 8; v++) begin
      phase_name = $sformatf("vec%0d", v);
      do_reset();
      load_idle(mk_board(vecs[v].red_cells, vecs[v].green_cells), vecs[v].mask);
      push_frame(vecs[v].exp_red, vecs[v].exp_green, LR_OFF);
      push_frame(vecs[v].exp_red, vecs[v].exp_green, LR_ON);
      drain();
    end

    // New board while row 1 is being shown; lights_ready drops from index 8.
    phase_name = "midframe_load";
    do_reset();
    load_idle(mk_board(MENU_CELLS, MENU_CELLS), 9'h000);
    push_frame(MENU_ROWS, MENU_ROWS, LR_OFF);
    push_frame(MENU_ROWS, MENU_ROWS, 15'h00FF);
    push_frame(9'h000, 9'h000, LR_OFF);
    push_frame(9'h000, 9'h000, LR_ON);
    check_n(15 + 8);
    pulse_load(mk_board(9'h000, 9'h000), 9'h000);
    drain();

    phase_name = "two_loads";
    do_reset();
    load_idle(mk_board(9'h000, 9'h000), 9'h000);
    push_frame(9'h000, 9'h000, LR_OFF);
    push_frame(9'h000, 9'h1FF, LR_OFF);
    push_frame(9'h000, 9'h1FF, LR_ON);
    check_n(3);
    pulse_load(mk_board(9'h1FF, 9'h000), 9'h000);
    check_n(6);
    pulse_load(mk_board(9'h000, 9'h1FF), 9'h000);
    drain();

    phase_name = "blink";
    do_reset();
    load_idle(mk_board(9'h1FF, 9'h000), 9'h1FF);
    push_frame(9'h1FF, 9'h000, LR_OFF);
    push_frame(9'h1FF, 9'h000, LR_ON);
    push_frame(9'h000, 9'h000, LR_ON);
    push_frame(9'h000, 9'h000, LR_ON);
    push_frame(9'h1FF, 9'h000, LR_ON);
    drain();

    // Reset during row 2 SHOW, with a simultaneous load that must be ignored.
    phase_name = "reset_row2";
    do_reset();
    load_idle(mk_board(MENU_CELLS, MENU_CELLS), 9'h000);
    push_frame(MENU_ROWS, MENU_ROWS, LR_OFF);
    check_n(13);
    sb_q.delete();
    rst          = 1'b1;
    bus.board    = mk_board(9'h1FF, 9'h000);
    bus.win_mask = 9'h000;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.load = 1'b0;
    push_dark(6);
    drain();
    phase_name = "restart";
    load_idle(mk_board(MENU_CELLS, MENU_CELLS), 9'h000);
    push_frame(MENU_ROWS, MENU_ROWS, LR_OFF);
    push_frame(MENU_ROWS, MENU_ROWS, LR_ON);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
